// File: rtl/aha_clock_gate_ctrl_if.sv
// Interface bundling the request/acknowledge and gated-clock signals of aha_clock_gate_ctrl.
// The master side drives requests and test enable; the slave side is the controller.
interface aha_clock_gate_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int IDLE_W = 8,
    parameter int STAT_W = 16
);
    logic                       te;
    logic [NUM_CH-1:0]          req;
    logic [NUM_CH-1:0]          force_on;
    logic [IDLE_W-1:0]          idle_timeout;
    logic [NUM_CH-1:0]          ack;
    logic [NUM_CH-1:0]          ch_on;
    logic [NUM_CH-1:0]          gclk;
    logic [NUM_CH*STAT_W-1:0]   stat_gated;

    modport master (
        output te, req, force_on, idle_timeout,
        input  ack, ch_on, gclk, stat_gated
    );

    modport slave (
        input  te, req, force_on, idle_timeout,
        output ack, ch_on, gclk, stat_gated
    );
endinterface

// File: rtl/aha_clock_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel wake/idle FSM feeding a latch-based ICG.
// Optional gated-cycle statistics are built only when AHA_CLKGATE_STATS_EN is defined.
module aha_clock_gate_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2,
    parameter int STAT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aha_clock_gate_ctrl_if.slave cg
);

    localparam int WAKE_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam int CNT_W  = (IDLE_W > WAKE_W) ? IDLE_W : WAKE_W;
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    state_t             state_r [NUM_CH];
    logic [CNT_W-1:0]   cnt_r   [NUM_CH];
    logic [NUM_CH-1:0]  en_r;
    logic [NUM_CH-1:0]  ack_r;
    logic [NUM_CH-1:0]  lat_r;
    logic [NUM_CH-1:0]  wreq_s;

    assign wreq_s = cg.req | cg.force_on;

    // Per-channel wake / run / idle-timeout state machines with registered en and ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i] <= ST_OFF;
                cnt_r[i]   <= CNT_ZERO;
            end
            en_r  <= {NUM_CH{1'b0}};
            ack_r <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                case (state_r[i])
                    ST_OFF: begin
                        if (wreq_s[i]) begin
                            state_r[i] <= ST_WAKE;
                            en_r[i]    <= 1'b1;
                            cnt_r[i]   <= WAKE_LOAD;
                        end
                    end
                    ST_WAKE: begin
                        // A dropped request does not abort a wake already in progress
                        if (cnt_r[i] == CNT_ZERO) begin
                            state_r[i] <= ST_ON;
                            ack_r[i]   <= 1'b1;
                        end else begin
                            cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                        end
                    end
                    ST_ON: begin
                        if (!wreq_s[i]) begin
                            if (cg.idle_timeout == {IDLE_W{1'b0}}) begin
                                state_r[i] <= ST_OFF;
                                en_r[i]    <= 1'b0;
                                ack_r[i]   <= 1'b0;
                            end else begin
                                state_r[i] <= ST_IDLE;
                                cnt_r[i]   <= CNT_W'(cg.idle_timeout - IDLE_W'(1));
                            end
                        end
                    end
                    ST_IDLE: begin
                        // Request has priority over an expiring timeout
                        if (wreq_s[i]) begin
                            state_r[i] <= ST_ON;
                        end else if (cnt_r[i] == CNT_ZERO) begin
                            state_r[i] <= ST_OFF;
                            en_r[i]    <= 1'b0;
                            ack_r[i]   <= 1'b0;
                        end else begin
                            cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_r[i] <= ST_OFF;
                        en_r[i]    <= 1'b0;
                        ack_r[i]   <= 1'b0;
                        cnt_r[i]   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    // ICG latch: transparent while clk is low so enable changes never clip a high phase
    always_latch begin
        if (!rst_n) begin
            lat_r <= {NUM_CH{1'b0}};
        end else if (!clk) begin
            lat_r <= en_r | {NUM_CH{cg.te}};
        end
    end

    assign cg.gclk  = {NUM_CH{clk}} & lat_r;
    assign cg.ack   = ack_r;
    assign cg.ch_on = en_r;

`ifdef AHA_CLKGATE_STATS_EN
    logic [STAT_W-1:0] stat_r [NUM_CH];

    // Saturating count of edges seen with the channel gated off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stat_r[i] <= {STAT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!en_r[i] && (stat_r[i] != {STAT_W{1'b1}})) begin
                    stat_r[i] <= stat_r[i] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
        assign cg.stat_gated[g*STAT_W +: STAT_W] = stat_r[g];
    end
`else
    assign cg.stat_gated = {NUM_CH*STAT_W{1'b0}};
`endif

endmodule
